bs_select_sequencer: RTL
========================

BS_SELECT_SEQUENCER -- requirements
Module: bs_select_sequencer

Interface
REQ-001 SHALL have parameter BS, default 8: number of bitstream output channels driven in parallel.
REQ-002 SHALL have parameter NUM_BS, default 256: bitstreams in the group; NUM_BS_SELECT = log2(NUM_BS), default 8.
REQ-003 SHALL have parameter DUR_W, default 8: width of the hold-duration field.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: instruction queue depth, a power of two.
REQ-005 SHALL have parameter IDLE_SEL, default 0: select code driven by an idle channel.
REQ-006 SHALL have the port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have the port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have the port instr_valid, input, 1: instruction offered.
REQ-009 SHALL have the port instr_ready, output, 1: instruction can be accepted.
REQ-010 SHALL have the port instr_ch, input, log2(BS): target output channel.
REQ-011 SHALL have the port instr_sel, input, NUM_BS_SELECT: bitstream index to route onto the channel.
REQ-012 SHALL have the port instr_dur, input, DUR_W: hold time in cycles.
REQ-013 SHALL have the port abort, input, 1: synchronous flush of the queue and all channels.
REQ-014 SHALL have the port bs_select, output, NUM_BS_SELECT*BS: flat select bus; channel i occupies bits [NUM_BS_SELECT*i +: NUM_BS_SELECT], feeding the downstream bitstream mux.
REQ-015 SHALL have the port busy, output, BS: channel i is currently holding an instruction.
REQ-016 SHALL have the port fifo_count, output, log2(FIFO_DEPTH)+1: number of queued instructions.

Function
REQ-017 SHALL accept an instruction on any rising edge where instr_valid and instr_ready are both high, pushing {ch, sel, dur} into the FIFO.
REQ-018 SHALL drive instr_ready = !full, a function of registered state only; there is no push-when-full pass-through, even when a pop occurs in the same cycle.
REQ-019 SHALL issue the FIFO head in order, with head-of-line blocking, when channel head.ch is free, i.e. busy[ch]=0 or that channel's counter equals 1 (seamless back-to-back).
REQ-020 SHALL, on issue of a head with dur>=1, set sel_reg[ch]=head.sel, cnt[ch]=head.dur and busy[ch]=1 at the same edge the head is popped.
REQ-021 SHALL pop and discard a head with dur=0 with no effect on any channel.
REQ-022 SHALL decrement cnt[i] each cycle while busy[i]=1; at the edge where cnt[i]=1 and no new issue targets channel i, it SHALL set busy[i]=0 and sel_reg[i]=IDLE_SEL.
REQ-023 SHALL give the instruction timing as follows: accepted at edge t, issued no earlier than edge t+1, held on bs_select for exactly dur cycles, reverted at issue edge + dur.
REQ-024 SHALL issue at most one instruction per cycle, allow a simultaneous push and pop when not full, and update fifo_count by push minus pop.
REQ-025 SHALL have FIFO pointers that wrap modulo FIFO_DEPTH, with a count-based full/empty decision.
REQ-026 SHALL, when abort is high at an edge, empty the FIFO, clear all busy bits, set all sel_reg to IDLE_SEL, and ignore any push or issue in that cycle.
REQ-027 SHALL drive bs_select and busy directly from registers, with no combinational path from inputs.

Reset
REQ-028 SHALL, while rst_n=0, immediately clear the FIFO and force fifo_count=0, busy=0, every bs_select field=IDLE_SEL and instr_ready=0.
REQ-029 SHALL raise instr_ready on the first edge after rst_n deasserts; a reset mid-hold drops the active instruction without completing it.

Verification
REQ-030 Single issue: push {ch=3, sel=0x5A, dur=4} at edge 0 -> channel 3 field = 0x5A after edges 1-4 and IDLE_SEL after edge 5; busy[3] high for exactly 4 cycles.
REQ-031 Back-to-back: push {2, 0x10, 2} then {2, 0x20, 3} -> channel 2 shows 0x10 for 2 cycles, then 0x20 for 3 cycles, with no idle gap.
REQ-032 Head-of-line block: {1, 0x01, 5}, {1, 0x02, 1}, {4, 0x04, 1} -> the channel-4 instruction waits until the second channel-1 instruction issues.
REQ-033 Full: 5 pushes with channel 0 blocked -> instr_ready=0 while fifo_count=4; the fifth push is accepted only after a pop.
REQ-034 dur=0 push -> popped in one cycle, bs_select unchanged, busy unchanged.
REQ-035 Abort or rst_n low mid-hold with 3 queued -> all fields IDLE_SEL, fifo_count=0 (asynchronously for rst_n, next edge for abort).

Source files
------------

// File: rtl/bs_select_sequencer.sv
// bs_select_sequencer: queues {channel, select, duration} instructions and holds each
// select code on its output channel for the requested number of cycles.
module bs_select_sequencer #(
  parameter int BS = 8,
  parameter int NUM_BS = 256,
  parameter int DUR_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_SEL = 0,
  localparam int NUM_BS_SELECT = $clog2(NUM_BS),
  localparam int CH_W = BS > 1 ? $clog2(BS) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [CH_W-1:0]             instr_ch,
  input  logic [NUM_BS_SELECT-1:0]    instr_sel,
  input  logic [DUR_W-1:0]            instr_dur,
  input  logic                        abort,
  output logic [NUM_BS_SELECT*BS-1:0] bs_select,
  output logic [BS-1:0]               busy,
  output logic [CNT_W-1:0]            fifo_count
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = CH_W + NUM_BS_SELECT + DUR_W;
  localparam logic [NUM_BS_SELECT-1:0] IDLE = NUM_BS_SELECT'(IDLE_SEL);
  localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic ready_q;
  logic [CH_W-1:0] head_ch;
  logic [NUM_BS_SELECT-1:0] head_sel;
  logic [DUR_W-1:0] head_dur;
  logic [NUM_BS_SELECT-1:0] sel_reg [BS];
  logic [DUR_W-1:0] cnt [BS];
  logic push, pop, issue, ch_free;
  logic [BS-1:0] issue_vec;
  assign {head_ch, head_sel, head_dur} = mem[rd_ptr];
  // ready_q keeps instr_ready low while in reset and until the first edge after it
  assign instr_ready = ready_q && fifo_count != CNT_W'(FIFO_DEPTH);
  assign push = instr_valid && instr_ready && !abort;
  assign ch_free = !busy[head_ch] || cnt[head_ch] == DUR_W'(1);
  assign pop = !abort && fifo_count != '0 && (head_dur == '0 || ch_free);
  assign issue = pop && head_dur != '0;
  assign issue_vec = issue ? BS'(1) << head_ch : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ready_q <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      ready_q <= 1'b1;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {instr_ch, instr_sel, instr_dur};
  // A new issue wins over the expiry of the current hold, giving seamless back-to-back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      for (int k = 0; k < BS; k++) begin
        sel_reg[k] <= IDLE;
        cnt[k] <= '0;
      end
    end else if (abort) begin
      busy <= '0;
      for (int k = 0; k < BS; k++) begin
        sel_reg[k] <= IDLE;
        cnt[k] <= '0;
      end
    end else
      for (int k = 0; k < BS; k++)
        if (issue_vec[k]) begin
          busy[k] <= 1'b1;
          sel_reg[k] <= head_sel;
          cnt[k] <= head_dur;
        end else if (busy[k]) begin
          busy[k] <= cnt[k] != DUR_W'(1);
          sel_reg[k] <= cnt[k] == DUR_W'(1) ? IDLE : sel_reg[k];
          cnt[k] <= cnt[k] - 1'b1;
        end
  for (genvar i = 0; i < BS; i++) begin : g_out
    assign bs_select[NUM_BS_SELECT*i +: NUM_BS_SELECT] = sel_reg[i];
  end
endmodule
